// File: rtl/rgb_cmd_pwm.sv
// rgb_cmd_pwm: parses 0x5F,R,G,B colour frames and drives 3-channel 8-bit PWM on LED[2:0].
// Define RGB_CMD_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES idle cycles.
module rgb_cmd_pwm_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cnt,
  input  logic [7:0] duty,
  output logic       led
);
  always_ff @(posedge clk or posedge rst)
    if (rst) led <= 1'b0;
    else     led <= (cnt < duty);
endmodule

module rgb_cmd_pwm #(
  parameter int         PWM_DIV        = 4,
  parameter int         TIMEOUT_CYCLES = 100_000,
  parameter logic [7:0] HEADER         = 8'h5F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [2:0] LED,
  output logic       frame_ok,
  output logic       frame_err
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;
  localparam int PW        = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  typedef enum logic [1:0] {IDLE, GET_R, GET_G, GET_B} state_t;

  state_t                          state;
  logic [NUM_LANES-1:0][VEC_W-1:0] shadow, duty;
  logic                            pending;
  logic [PW-1:0]                   pre;
  logic [VEC_W-1:0]                cnt;
  logic                            tick, load, timeout, b_landing;

  assign tick      = (pre == PW'(PWM_DIV - 1));
  assign b_landing = rx_valid && (state == GET_B);
  // Hold off the copy while the blue byte is being written so a frame is never split.
  assign load      = tick && (cnt == 8'hFF) && pending && !b_landing;

`ifdef RGB_CMD_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES);
  logic [GW-1:0] gap;

  assign timeout = (state != IDLE) && !rx_valid && (gap == GW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst)                                       gap <= '0;
    else if (rx_valid || state == IDLE || timeout) gap <= '0;
    else                                           gap <= gap + GW'(1);
`else
  // Never true for a legal TIMEOUT_CYCLES; partial frames wait forever.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      pending   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (load) pending <= 1'b0;
      if (rx_valid) begin
        unique case (state)
          IDLE:  if (rx_data == HEADER) state <= GET_R;
                 else                   frame_err <= 1'b1;
          GET_R: begin shadow[2] <= rx_data; state <= GET_G; end
          GET_G: begin shadow[1] <= rx_data; state <= GET_B; end
          GET_B: begin
            shadow[0] <= rx_data;
            pending   <= 1'b1;
            frame_ok  <= 1'b1;
            state     <= IDLE;
          end
        endcase
      end else if (timeout) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre  <= '0;
      cnt  <= '0;
      duty <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) cnt  <= cnt + 8'd1;
      if (load) duty <= shadow;
    end

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    rgb_cmd_pwm_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt),
      .duty (duty[c]),
      .led  (LED[c])
    );
  end
endmodule

// File: tb/tb_rgb_cmd_pwm.sv
// Directed + randomized bench for rgb_cmd_pwm with a frame-level reference model.
module tb_rgb_cmd_pwm;
  localparam int         PWM_DIV = 4;
  localparam int         TMO     = 50;
  localparam int         PERIOD  = 256 * PWM_DIV;
  localparam logic [7:0] HDR     = 8'h5F;

  logic       clk = 1'b0, rst = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [2:0] LED;
  logic       frame_ok, frame_err;

  int          n_chk = 0, n_fail = 0;
  int unsigned cyc;
  logic [2:0]  led_q = 3'b000;

  // model: bytes collected so far in the current frame, and last accepted duties
  int          mstage = 0;
  logic [7:0]  mbuf [3];
  logic [7:0]  lr = 0, lg = 0, lb = 0;

  rgb_cmd_pwm #(.PWM_DIV(PWM_DIV), .TIMEOUT_CYCLES(TMO), .HEADER(HDR)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .LED(LED), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // clock edges since reset release; PWM periods start at multiples of PERIOD
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // an LED may only switch on in the first step of a period
  always @(negedge clk) begin
    if (!rst)
      for (int c = 0; c < 3; c++)
        if (LED[c] && !led_q[c]) check("led_rise_align", cyc % PERIOD, 1);
    led_q = rst ? 3'b000 : LED;
  end

  function automatic logic [2:0] exp_led(input logic [7:0] r, g, b);
    int step;
    step = int'(((cyc - 1) / PWM_DIV) % 256);
    return {step < int'(r), step < int'(g), step < int'(b)};
  endfunction

  task automatic model_byte(input logic [7:0] b, output logic eok, output logic eerr);
    eok = 1'b0; eerr = 1'b0;
    if (mstage == 0) begin
      if (b == HDR) mstage = 1; else eerr = 1'b1;
    end else begin
      mbuf[mstage-1] = b;
      mstage++;
      if (mstage == 4) begin
        mstage = 0; eok = 1'b1;
        lr = mbuf[0]; lg = mbuf[1]; lb = mbuf[2];
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    logic eok, eerr;
    model_byte(b, eok, eerr);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
    check({tag, ".ok"},  frame_ok,  eok);
    check({tag, ".err"}, frame_err, eerr);
    @(negedge clk);
    check({tag, ".pulse_end"}, {frame_ok, frame_err}, 2'b00);
  endtask

  task automatic send_frame_b2b(input logic [7:0] r, g, b, input string tag);
    logic [7:0] q [4];
    logic eok, eerr;
    q = '{HDR, r, g, b};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      model_byte(q[i], eok, eerr);
      rx_valid = 1'b1; rx_data = q[i];
      @(negedge clk);
      check({tag, ".b2b"}, {frame_ok, frame_err}, {eok, eerr});
    end
    rx_valid = 1'b0;
    @(negedge clk);
    check({tag, ".b2b_end"}, {frame_ok, frame_err}, 2'b00);
  endtask

  task automatic measure(input string tag);
    int hc [3];
    repeat (2 * PERIOD) @(negedge clk);
    hc = '{0, 0, 0};
    repeat (PERIOD) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) hc[c] += int'(LED[c]);
    end
    check({tag, ".red"},   hc[2], int'(lr) * PWM_DIV);
    check({tag, ".green"}, hc[1], int'(lg) * PWM_DIV);
    check({tag, ".blue"},  hc[0], int'(lb) * PWM_DIV);
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    @(negedge clk);
    while (int'(cyc % PERIOD) != ph && n < 2 * PERIOD) begin @(negedge clk); n++; end
    check("wait_phase_bound", n < 2 * PERIOD, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, g, b, j;
    logic [2:0] old_exp;
    int first_k, n_err;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.led", LED, 3'b000);
    check("reset.pulses", {frame_ok, frame_err}, 2'b00);
    rst = 1'b0;

    // basic frame with long gaps between bytes
    send(HDR, "f1.hdr");   repeat (1000) @(negedge clk);
    send(8'h2A, "f1.r");   repeat (1000) @(negedge clk);
    send(8'h42, "f1.g");   repeat (1000) @(negedge clk);
    send(8'h7A, "f1.b");
    measure("f1");

    // junk in IDLE: error pulse, duties untouched
    send(8'h2A, "idle_junk");
    measure("idle_junk");

    send(HDR, "ext.hdr"); send(8'h00, "ext.r"); send(8'hFF, "ext.g"); send(8'h80, "ext.b");
    measure("extremes");

    // two frames in one period: the later one wins at the boundary
    wait_phase(16);
    old_exp = 3'b000;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    send_frame_b2b(r, g, b, "lfw.a");
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    old_exp = exp_led(8'h00, 8'hFF, 8'h80);
    check("lfw.old_led", LED, old_exp);
    send_frame_b2b(r, g, b, "lfw.b");
    measure("lfw");

`ifdef RGB_CMD_TIMEOUT_EN
    send(HDR, "tmo.hdr"); send(8'h11, "tmo.r");
    first_k = -1; n_err = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_err) begin n_err++; if (first_k < 0) first_k = k; end
    end
    check("tmo.when",  first_k, 48);
    check("tmo.count", n_err, 1);
    mstage = 0;
    send(HDR, "tmo2.hdr"); send(8'h01, "tmo2.r"); send(8'h02, "tmo2.g"); send(8'h03, "tmo2.b");
    measure("tmo2");
`else
    send(HDR, "wait.hdr"); send(8'h11, "wait.r");
    n_err = 0;
    repeat (200) begin @(negedge clk); if (frame_err) n_err++; end
    check("wait.no_err", n_err, 0);
    first_k = 0;
    send(8'h22, "wait.g"); send(8'h33, "wait.b");
    measure("wait");
`endif

    // asynchronous reset in the middle of a frame
    send(HDR, "pre.hdr"); send(8'hC0, "pre.r"); send(8'hC0, "pre.g"); send(8'hC0, "pre.b");
    measure("pre_rst");
    wait_phase(8);
    send(HDR, "mid.hdr"); send(8'h2A, "mid.r");
    check("mid.led_on", LED, exp_led(lr, lg, lb));
    #2 rst = 1'b1;
    #1 check("async_rst.led", LED, 3'b000);
    check("async_rst.pulses", {frame_ok, frame_err}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mstage = 0; lr = 0; lg = 0; lb = 0;
    send(8'h01, "post.1"); send(8'h02, "post.2"); send(8'h03, "post.3");
    measure("post_rst");

    // randomized frames, junk bytes and gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom);
        if (j == HDR) j = j + 8'd1;
        send(j, "rnd.junk");
      end
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      if (i == 2) g = HDR;
      if (i % 2 == 0) send_frame_b2b(r, g, b, "rnd.b2b");
      else begin
        send(HDR, "rnd.hdr"); repeat ($urandom_range(0, 20)) @(negedge clk);
        send(r,   "rnd.r");   repeat ($urandom_range(0, 20)) @(negedge clk);
        send(g,   "rnd.g");   repeat ($urandom_range(0, 20)) @(negedge clk);
        send(b,   "rnd.b");
      end
      measure("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
